mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Multicycle control unit for the next-generation MIPS core. It replaces the single-cycle controller with a state machine that sequences one shared memory port and one ALU over several cycles per instruction. Memory accesses can optionally stall on a ready handshake. The decoder extends the single-cycle instruction set with `bne`, `andi`, `ori` and `slti`. It drives the multicycle datapath and exports a retired-instruction counter.

## Interface
Parameters:
- `MEM_HANDSHAKE`, default 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored, every access completes in one cycle.
- `EXT_OPS`, default 1: 1 = `bne`, `andi`, `ori`, `slti` decoded; 0 = those opcodes are illegal.
- `CNT_W`, default 32: width of `instret`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  6  `instr[31:26]` from the instruction register.
- `funct`  in  6  `instr[5:0]`.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `pcen`  out  1  PC write enable.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memread`  out  1  memory read request.
- `memwrite`  out  1  memory write request.
- `irwrite`  out  1  instruction register load.
- `regdst`  out  1  destination register select: 1 = rd, 0 = rt.
- `memtoreg`  out  1  register write data: 1 = MDR, 0 = ALUOut.
- `regwrite`  out  1  register file write.
- `alusrca`  out  1  ALU A: 0 = PC, 1 = rs.
- `alusrcb`  out  2  ALU B: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `immzext`  out  1  immediate is zero-extended instead of sign-extended (`andi`, `ori`).
- `pcsrc`  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal`  out  1  one-cycle pulse on an unrecognised instruction.
- `instret`  out  `CNT_W`  count of retired instructions.

## Operation
- Moore FSM. Outputs decode from the current state. Exceptions:
  - `pcen = pcwrite | (branch & (zero ^ is_bne))`.
  - `irwrite` and the FETCH `pcwrite` are gated by the memory handshake.
- States and transitions:
  - FETCH: `memread`, `irwrite`, `pcwrite`, `alusrcb` = 01, add. Goes to DECODE.
  - DECODE: `alusrcb` = 11, add. Branches on `op`:
    - lw/sw → MEMADR
    - R-type → REXEC
    - beq/bne → BRANCH
    - addi/slti/andi/ori → IEXEC
    - j → JUMP
    - otherwise → FETCH with `illegal` = 1
  - MEMADR: `alusrca` = 1, `alusrcb` = 10, add. lw → MEMRD; sw → MEMWR.
  - MEMRD: `iord`, `memread`. Goes to MEMWB.
  - MEMWB: `regwrite`, `memtoreg`, rt destination. Goes to FETCH.
  - MEMWR: `iord`, `memwrite`. Goes to FETCH.
  - REXEC: `alusrca` = 1, `alusrcb` = 00, ALU op from `funct`. Goes to RWB.
  - RWB: `regwrite`, `regdst`. Goes to FETCH.
  - BRANCH: `alusrca` = 1, sub, `branch`, `pcsrc` = 01. Goes to FETCH.
  - IEXEC: `alusrca` = 1, `alusrcb` = 10, ALU op from `op`, `immzext` for andi/ori. Goes to IWB.
  - IWB: `regwrite`, rt destination. Goes to FETCH.
  - JUMP: `pcwrite`, `pcsrc` = 10. Goes to FETCH.
- R-type `funct` decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other `funct` is illegal and is detected in DECODE.
- Memory states (FETCH, MEMRD, MEMWR) with `MEM_HANDSHAKE` = 1:
  - The FSM holds while `mem_ready` = 0.
  - `memread`/`memwrite` stay asserted while holding.
  - `irwrite`/`pcwrite` assert only in the cycle with `mem_ready` = 1.
- `instret` increments on leaving MEMWB, MEMWR, RWB, BRANCH, IWB or JUMP. It wraps modulo 2^`CNT_W`. Illegal instructions are not counted.
- Reset (`reset` = 0, asynchronous, may arrive mid-instruction):
  - state → FETCH, `instret` → 0.
  - `pcen`, `irwrite`, `regwrite`, `memwrite`, `memread`, `illegal` all forced to 0.
  - All other outputs take their FETCH values: `iord` 0, `alusrca` 0, `alusrcb` 01, `alucontrol` 010, `pcsrc` 00, `regdst` 0, `memtoreg` 0, `immzext` 0.

## Timing
- Cycles per instruction with zero wait states:

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw | 4 |
| R-type | 4 |
| addi/andi/ori/slti | 4 |
| beq/bne | 3 |
| j | 3 |
| illegal | 2 |

- Each cycle `mem_ready` is low in a memory state adds exactly one cycle.
- `illegal` is high only during the DECODE cycle.
- `instret` updates on the clock edge that leaves the final state of the instruction.
- After `reset` deasserts, the first rising edge samples FETCH.

## Structure
- Package `mips_mc_pkg` holds:
  - the state enum
  - opcode constants
  - funct constants
  - ALU control constants
  - `alusrcb`/`pcsrc` encodings
- One sub-module, `mips_mc_aludec`: combinational mapping of `op`/`funct` to `alucontrol`, `immzext` and an illegal flag.

## Test plan
- lw, `mem_ready` held at 1:
  - states run FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - `regwrite` = 1 with `memtoreg` = 1 in cycle 5.
  - `instret` 0 → 1.
- sw with `mem_ready` low for 3 cycles in MEMWR:
  - `memwrite` stays high for 4 cycles.
  - total 7 cycles.
  - `regwrite` never asserts.
- beq and bne with `zero` = 1 and `zero` = 0 (all four combinations):
  - `pcen` = 1 in BRANCH only for beq/zero = 1 and bne/zero = 0.
  - `alucontrol` = 110 in BRANCH.
- R-type `funct` = 101010: `alucontrol` = 111 in REXEC and `regdst` = 1 in RWB.
- R-type `funct` = 100111: `illegal` pulses in DECODE, then FETCH, `instret` unchanged.
- With `EXT_OPS` = 0, `op` = 001101 (ori): `illegal` pulses.
- ori with `EXT_OPS` = 1: `immzext` = 1 and `alucontrol` = 001.
- `reset` = 0 asserted mid-MEMRD, asynchronous to `clk`:
  - outputs immediately take reset values.
  - `instret` = 0.
  - after release, FETCH `memread` = 1.
- 2^`CNT_W` retirements with `CNT_W` = 4: `instret` wraps 15 → 0.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_REXEC, S_RWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_aludec.sv
// Maps op/funct to the execute-stage ALU operation, immediate extension
// mode and an illegal-instruction flag.
module mips_mc_aludec
    import mips_mc_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       immzext,
    output logic       illegal
);

    always_comb begin
        alucontrol = ALU_ADD;
        immzext    = 1'b0;
        illegal    = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: illegal    = 1'b1;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: alucontrol = ALU_ADD;
            OP_BNE:  illegal = (EXT_OPS == 0);
            OP_SLTI: begin
                alucontrol = ALU_SLT;
                illegal    = (EXT_OPS == 0);
            end
            OP_ANDI: begin
                alucontrol = ALU_AND;
                immzext    = 1'b1;
                illegal    = (EXT_OPS == 0);
            end
            OP_ORI: begin
                alucontrol = ALU_OR;
                immzext    = 1'b1;
                illegal    = (EXT_OPS == 0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM sharing one memory port and one ALU.
// state | meaning
// FETCH read instr, PC+4 | DECODE branch target, dispatch | MEMADR lw/sw address
// MEMRD load read | MEMWB load writeback | MEMWR store | REXEC/RWB R-type
// BRANCH beq/bne compare | IEXEC/IWB immediate ops | JUMP j
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int EXT_OPS       = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcen,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             immzext,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t     state, state_next;
    logic       mem_ok, pcwrite, branch, retire;
    logic [2:0] dec_alu;
    logic       dec_zext, dec_illegal;

    assign mem_ok = (MEM_HANDSHAKE == 0) || mem_ready;

    mips_mc_aludec #(.EXT_OPS(EXT_OPS)) u_aludec (
        .op         (op),
        .funct      (funct),
        .alucontrol (dec_alu),
        .immzext    (dec_zext),
        .illegal    (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ok) state_next = S_DECODE;
            S_DECODE: begin
                if (dec_illegal) state_next = S_FETCH;
                else begin
                    case (op)
                        OP_LW, OP_SW:                       state_next = S_MEMADR;
                        OP_RTYPE:                           state_next = S_REXEC;
                        OP_BEQ, OP_BNE:                     state_next = S_BRANCH;
                        OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_next = S_IEXEC;
                        OP_J:                               state_next = S_JUMP;
                        default:                            state_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ok) state_next = S_MEMWB;
            S_MEMWR:  if (mem_ok) state_next = S_FETCH;
            S_REXEC:  state_next = S_RWB;
            S_IEXEC:  state_next = S_IWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        retire     = 1'b0;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_RT;
        immzext    = 1'b0;
        pcsrc      = PCSRC_ALU;
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                memread = 1'b1;
                irwrite = mem_ok;
                pcwrite = mem_ok;
                alusrcb = SRCB_FOUR;
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                illegal = dec_illegal;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = mem_ok;
            end
            S_REXEC: begin
                alusrca    = 1'b1;
                alucontrol = dec_alu;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsrc      = PCSRC_ALUOUT;
                retire     = 1'b1;
            end
            S_IEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                alucontrol = dec_alu;
                immzext    = dec_zext;
            end
            S_IWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            S_JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = PCSRC_JUMP;
                retire  = 1'b1;
            end
            default: retire = 1'b0;
        endcase
        // Reset is asynchronous, so strobes are silenced combinationally too.
        if (!reset) begin
            pcwrite  = 1'b0;
            branch   = 1'b0;
            memread  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
        pcen = pcwrite | (branch & (zero ^ (op == OP_BNE)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomised self-checking bench for mips_mc_controller against a
// per-instruction micro-step model built from the instruction semantics.
module tb_mips_mc_controller;

    localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
    localparam logic [5:0] SLTI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] JMP = 6'b000010;

    localparam int B_PCEN = 17, B_IORD = 16, B_MRD = 15, B_MWR = 14, B_IRW = 13;
    localparam int B_RDST = 12, B_M2R = 11, B_RW = 10, B_SRCA = 9, B_SRCB = 7;
    localparam int B_PCS = 5, B_ALU = 2, B_ZX = 1, B_ILL = 0;
    localparam logic [17:0] STROBES   = 18'b10_1110_0100_0000_0001;
    localparam logic [17:0] RESET_VEC = {9'b0, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, zero, mem_ready;
    logic [5:0] op, funct;

    logic pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic alusrca, immzext, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] instret;

    logic x_pcen, x_iord, x_memread, x_memwrite, x_irwrite, x_regdst, x_memtoreg;
    logic x_regwrite, x_alusrca, x_immzext, x_illegal;
    logic [1:0] x_alusrcb, x_pcsrc;
    logic [2:0] x_alucontrol;
    logic [7:0] x_instret;

    mips_mc_controller #(.MEM_HANDSHAKE(1), .EXT_OPS(1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .immzext(immzext), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal(illegal), .instret(instret)
    );

    mips_mc_controller #(.MEM_HANDSHAKE(0), .EXT_OPS(0), .CNT_W(8)) dut_x (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(x_pcen), .iord(x_iord), .memread(x_memread),
        .memwrite(x_memwrite), .irwrite(x_irwrite), .regdst(x_regdst),
        .memtoreg(x_memtoreg), .regwrite(x_regwrite), .alusrca(x_alusrca),
        .alusrcb(x_alusrcb), .immzext(x_immzext), .pcsrc(x_pcsrc),
        .alucontrol(x_alucontrol), .illegal(x_illegal), .instret(x_instret)
    );

    typedef struct {
        logic [17:0] val;
        logic [17:0] msk;
        bit          ismem;
        bit          rdy;
    } step_t;

    step_t q[$];
    logic [17:0] cv, cm;
    int exp_count, n_cmp, n_err;

    function automatic logic [17:0] outs();
        return {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, pcsrc, alucontrol, immzext, illegal};
    endfunction

    function automatic logic [17:0] x_outs();
        return {x_pcen, x_iord, x_memread, x_memwrite, x_irwrite, x_regdst, x_memtoreg,
                x_regwrite, x_alusrca, x_alusrcb, x_pcsrc, x_alucontrol, x_immzext, x_illegal};
    endfunction

    function automatic bit model_illegal(logic [5:0] o, logic [5:0] f);
        case (o)
            R_OP: return !(f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
            LW, SW, BEQ, BNE, ADDI, SLTI, ANDI, ORI, JMP: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int model_alu(logic [5:0] o, logic [5:0] f);
        if (o == R_OP) begin
            case (f)
                6'b100010: return 6;
                6'b100100: return 0;
                6'b100101: return 1;
                6'b101010: return 7;
                default:   return 2;
            endcase
        end
        case (o)
            SLTI:    return 7;
            ANDI:    return 0;
            ORI:     return 1;
            default: return 2;
        endcase
    endfunction

    function automatic void begin_step();
        cv = '0;
        cm = STROBES;
    endfunction

    function automatic void fld(int lo, int w, int x);
        for (int i = 0; i < w; i++) begin
            cv[lo+i] = x[i];
            cm[lo+i] = 1'b1;
        end
    endfunction

    function automatic void end_step(bit ismem, bit rdy);
        step_t s;
        s.val = cv;
        s.msk = cm;
        s.ismem = ismem;
        s.rdy = rdy;
        q.push_back(s);
    endfunction

    // Expected per-cycle outputs of one instruction; returns 1 if it retires.
    function automatic bit build(logic [5:0] o, logic [5:0] f, logic z, int fw, int mw);
        bit ill;
        q.delete();
        for (int i = 0; i <= fw; i++) begin
            begin_step();
            cv[B_MRD] = 1'b1;
            fld(B_IORD, 1, 0); fld(B_SRCA, 1, 0); fld(B_SRCB, 2, 1);
            fld(B_PCS, 2, 0); fld(B_ALU, 3, 2);
            if (i == fw) begin
                cv[B_IRW] = 1'b1;
                cv[B_PCEN] = 1'b1;
            end
            end_step(1'b1, i == fw);
        end
        ill = model_illegal(o, f);
        begin_step();
        fld(B_SRCB, 2, 3); fld(B_ALU, 3, 2);
        cv[B_ILL] = ill;
        end_step(1'b0, 1'b0);
        if (ill) return 1'b0;
        case (o)
            LW, SW: begin
                begin_step();
                fld(B_SRCA, 1, 1); fld(B_SRCB, 2, 2); fld(B_ALU, 3, 2);
                end_step(1'b0, 1'b0);
                for (int i = 0; i <= mw; i++) begin
                    begin_step();
                    fld(B_IORD, 1, 1);
                    if (o == LW) cv[B_MRD] = 1'b1;
                    else         cv[B_MWR] = 1'b1;
                    end_step(1'b1, i == mw);
                end
                if (o == LW) begin
                    begin_step();
                    cv[B_RW] = 1'b1;
                    fld(B_M2R, 1, 1); fld(B_RDST, 1, 0);
                    end_step(1'b0, 1'b0);
                end
            end
            R_OP: begin
                begin_step();
                fld(B_SRCA, 1, 1); fld(B_SRCB, 2, 0); fld(B_ALU, 3, model_alu(o, f));
                end_step(1'b0, 1'b0);
                begin_step();
                cv[B_RW] = 1'b1;
                fld(B_RDST, 1, 1); fld(B_M2R, 1, 0);
                end_step(1'b0, 1'b0);
            end
            BEQ, BNE: begin
                begin_step();
                fld(B_SRCA, 1, 1); fld(B_ALU, 3, 6); fld(B_PCS, 2, 1);
                cv[B_PCEN] = (o == BNE) ? !z : z;
                end_step(1'b0, 1'b0);
            end
            JMP: begin
                begin_step();
                cv[B_PCEN] = 1'b1;
                fld(B_PCS, 2, 2);
                end_step(1'b0, 1'b0);
            end
            default: begin
                begin_step();
                fld(B_SRCA, 1, 1); fld(B_SRCB, 2, 2); fld(B_ALU, 3, model_alu(o, f));
                fld(B_ZX, 1, int'(o == ANDI || o == ORI));
                end_step(1'b0, 1'b0);
                begin_step();
                cv[B_RW] = 1'b1;
                fld(B_RDST, 1, 0); fld(B_M2R, 1, 0);
                end_step(1'b0, 1'b0);
            end
        endcase
        return 1'b1;
    endfunction

    // Runs the first 'stop' cycles of an instruction (all when stop < 0).
    task automatic run(string nm, logic [5:0] o, logic [5:0] f, logic z, int fw, int mw, int stop);
        bit legal;
        int n;
        legal = build(o, f, z, fw, mw);
        n = (stop < 0) ? q.size() : stop;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin
                op = o;
                funct = f;
                zero = z;
            end
            mem_ready = q[k].ismem ? q[k].rdy : 1'($urandom);
            #1;
            n_cmp++;
            if ((outs() & q[k].msk) !== (q[k].val & q[k].msk)) begin
                n_err++;
                $display("FAIL %s cycle %0d: outputs %b, expected %b under mask %b",
                         nm, k, outs(), q[k].val, q[k].msk);
            end
            if (k == 0) begin
                n_cmp++;
                if (instret !== 4'(exp_count)) begin
                    n_err++;
                    $display("FAIL %s instret at start: got %0d, expected %0d", nm, instret, 4'(exp_count));
                end
            end
        end
        if (legal && stop < 0) exp_count++;
    endtask

    task automatic check_count(string nm);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (instret !== 4'(exp_count) || memread !== 1'b1) begin
            n_err++;
            $display("FAIL %s: instret %0d memread %b, expected instret %0d memread 1",
                     nm, instret, memread, 4'(exp_count));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (outs() !== RESET_VEC || instret !== 4'd0) begin
            n_err++;
            $display("FAIL reset_values: outputs %b instret %0d, expected %b instret 0", outs(), instret, RESET_VEC);
        end
        n_cmp++;
        if (x_outs() !== RESET_VEC || x_instret !== 8'd0) begin
            n_err++;
            $display("FAIL reset_values_x: outputs %b instret %0d, expected %b instret 0", x_outs(), x_instret, RESET_VEC);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_lw();
        run("lw", LW, 6'h00, 1'b0, 0, 0, -1);
        check_count("lw_instret");
    endtask

    task automatic test_sw_wait();
        run("sw_wait3", SW, 6'h11, 1'b1, 0, 3, -1);
        check_count("sw_instret");
    endtask

    task automatic test_branch();
        run("beq_z1", BEQ, 6'h00, 1'b1, 0, 0, -1);
        run("beq_z0", BEQ, 6'h00, 1'b0, 1, 0, -1);
        run("bne_z1", BNE, 6'h00, 1'b1, 0, 0, -1);
        run("bne_z0", BNE, 6'h00, 1'b0, 0, 0, -1);
        check_count("branch_instret");
    endtask

    task automatic test_rtype();
        run("rtype_slt", R_OP, 6'b101010, 1'b0, 0, 0, -1);
        run("rtype_sub", R_OP, 6'b100010, 1'b0, 2, 0, -1);
        run("rtype_illegal", R_OP, 6'b100111, 1'b0, 0, 0, -1);
        check_count("illegal_instret");
    endtask

    task automatic test_ori();
        run("ori", ORI, 6'h2a, 1'b0, 0, 0, -1);
        run("andi", ANDI, 6'h00, 1'b0, 0, 0, -1);
        run("slti", SLTI, 6'h00, 1'b0, 1, 0, -1);
        check_count("imm_instret");
    endtask

    task automatic test_random();
        logic [5:0] pool_op [12] = '{R_OP, LW, SW, BEQ, BNE, ADDI, SLTI, ANDI, ORI, JMP, 6'h3f, 6'h01};
        logic [5:0] pool_fn [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'h00};
        logic [5:0] o, f;
        for (int i = 0; i < 60; i++) begin
            o = pool_op[$urandom_range(0, 11)];
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pool_fn[$urandom_range(0, 6)];
            run("random", o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
        check_count("random_instret");
    endtask

    task automatic test_reset_mid();
        run("pre_reset_j", JMP, 6'h00, 1'b0, 0, 0, -1);
        run("lw_to_memrd", LW, 6'h00, 1'b0, 0, 2, 4);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== RESET_VEC || instret !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid_memrd: outputs %b instret %0d, expected %b instret 0", outs(), instret, RESET_VEC);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        reset = 1'b1;
        exp_count = 0;
        #1;
        n_cmp++;
        if (memread !== 1'b1 || iord !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_fetch: memread %b iord %b, expected memread 1 iord 0", memread, iord);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_ext_off();
        logic [17:0] x;
        op = ORI;
        funct = 6'h00;
        do_reset();
        #1;
        x = x_outs();
        n_cmp++;
        if ({x[B_MRD], x[B_IRW], x[B_PCEN]} !== 3'b111) begin
            n_err++;
            $display("FAIL noext_fetch_nohandshake: memread/irwrite/pcen %b, expected 111", {x[B_MRD], x[B_IRW], x[B_PCEN]});
        end
        @(negedge clk); #1;
        n_cmp++;
        if (x_illegal !== 1'b1) begin
            n_err++;
            $display("FAIL noext_ori_illegal: illegal %b, expected 1", x_illegal);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (x_memread !== 1'b1 || x_illegal !== 1'b0 || x_instret !== 8'd0) begin
            n_err++;
            $display("FAIL noext_back_to_fetch: memread %b illegal %b instret %0d, expected 1 0 0", x_memread, x_illegal, x_instret);
        end
        op = LW;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (x_memread !== 1'b1 || x_iord !== 1'b1) begin
            n_err++;
            $display("FAIL noext_lw_memrd: memread %b iord %b, expected 1 1", x_memread, x_iord);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (x_regwrite !== 1'b1 || x_memtoreg !== 1'b1) begin
            n_err++;
            $display("FAIL noext_lw_memwb: regwrite %b memtoreg %b, expected 1 1", x_regwrite, x_memtoreg);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (x_instret !== 8'd1 || x_memread !== 1'b1) begin
            n_err++;
            $display("FAIL noext_lw_retire: instret %0d memread %b, expected 1 1", x_instret, x_memread);
        end
        n_cmp++;
        if (instret !== 4'd0 || memread !== 1'b1) begin
            n_err++;
            $display("FAIL main_held_in_fetch: instret %0d memread %b, expected 0 1", instret, memread);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) run("wrap_j", JMP, 6'h00, 1'b0, 0, 0, -1);
        check_count("wrap_at_15");
        run("wrap_j_last", JMP, 6'h00, 1'b0, 0, 0, -1);
        n_cmp++;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        if (instret !== 4'd0) begin
            n_err++;
            $display("FAIL wrap_to_zero: instret %0d, expected 0", instret);
        end
    endtask

    initial begin
        reset = 1'b0;
        mem_ready = 1'b0;
        op = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        n_cmp = 0;
        n_err = 0;
        exp_count = 0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_rtype();
        test_ori();
        test_random();
        test_reset_mid();
        test_ext_off();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
